data_memory_initiator: RTL and testbench
========================================

Name: data_memory_initiator

Overview:
- Synthesizable initiator for the phoeniX data memory interface; the load/store side of the protocol that the system memory responds to.
- Accepts one load/store request at a time from the execute/memory stage and drives enable, state, address, frame_mask and the shared data bus.
- Performs byte-lane alignment, load sign/zero extension, and splits misaligned accesses into two word beats.
- Returns one response per request.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = misaligned accesses split into two beats; 0 = misaligned accesses rejected with resp_error, no bus activity.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high (`ENABLE); one clock, no other clock domains.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted on posedge when req_valid && req_ready.
- req_write  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32 width code: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal.
- req_address  input  32  byte address.
- req_wdata  input  32  store data, LSB-justified.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  extended load result; 0 for stores and errors.
- resp_error  output  1  valid with resp_valid: illegal funct3, or misaligned access with SPLIT_MISALIGNED=0.
- data_memory_interface_enable  output  1  bus beat active.
- data_memory_interface_state  output  1  `READ or `WRITE.
- data_memory_interface_address  output  32  word-aligned beat address (low 2 bits 00).
- data_memory_interface_frame_mask  output  4  byte enables; mask[3-k] enables bits 8k+7:8k.
- data_memory_interface_data  inout  32  driven with lane-shifted store data during write beats; high-Z otherwise.

Behaviour:
Reset:
- Reset held: state IDLE; enable 0; state `READ; address 0; frame_mask 0; data bus Z; resp_valid 0; resp_rdata 0; resp_error 0; req_ready 0.
- req_ready is asserted from the first cycle after reset deasserts.

Request handling:
- Offset o = address[1:0]; size s = 1/2/4 bytes.
- Misaligned iff o + s > 4.
- Lanes used for beat 0: o .. min(o+s,4)-1. Lanes used for beat 1: 0 .. o+s-5.

FSM states: IDLE, BEAT0, BEAT1, RESP.
- IDLE: req_ready = 1. On accept:
  - Latch the request.
  - Illegal funct3, or misaligned with SPLIT_MISALIGNED=0 -> RESP with error.
  - Otherwise -> BEAT0.
- BEAT0: enable = 1; address = {addr[31:2],2'b00}; mask = beat-0 lanes.
  - Write: data = wdata << 8*o.
  - At the closing posedge, a read captures bus data into a low holding register.
  - Next state: misaligned -> BEAT1; else -> RESP.
- BEAT1: enable = 1; address = beat-0 address + 4; mask = beat-1 lanes.
  - Write: data = wdata >> 8*(4-o).
  - Read: capture into a high holding register. Next state: RESP.
- RESP: resp_valid = 1 for exactly one cycle. req_ready = 1, so back-to-back acceptance is allowed.
  - Accept in RESP -> BEAT0 or RESP by the same rules as IDLE.
  - Otherwise -> IDLE.

Load data assembly and extension:
- Merged value = {high, low} >> 8*o.
- Take the low s bytes; sign-extend for B/H, zero-extend for BU/HU/W.

Bus timing:
- Responder samples and drives data on the negedge inside the beat.
- Initiator samples read data only on the posedge ending the beat.
- Outside beats, enable = 0 and the data bus is Z.

Latency from accept posedge to resp_valid:
- Aligned: 2 cycles.
- Split: 3 cycles.
- Error: 1 cycle.

Other rules:
- Address wrap: 0xFFFF_FFFC + 4 wraps to 0x0000_0000 (32-bit add).
- Stores return resp_rdata = 0, resp_error = 0.
- Reset asserted during any state aborts immediately: no further beats, no response, all outputs at reset values.
- An accept during reset is ignored.

Test Plan:
1. Memory[0x100] = 0x8877_6655. lb 0x101 -> one beat (addr 0x100, mask 4'b0100, `READ); resp_rdata 0x0000_0066 two cycles after accept. lb 0x103 -> 0xFFFF_FF88. lbu 0x103 -> 0x0000_0088.
2. sh 0x102, wdata 0x0000_ABCD -> single `WRITE beat: addr 0x100, mask 4'b0011, bus 0xABCD_0000. Memory[0x100] becomes 0xABCD_6655; resp_valid with rdata 0.
3. Memory[0x100] = 0x4433_2211, Memory[0x104] = 0x8877_6655. lw 0x102 -> beats at 0x100 (mask 4'b0011) and 0x104 (mask 4'b1100); resp_rdata 0x6655_4433 three cycles after accept.
4. Same memory, sw 0x103 with 0xDDCC_BBAA -> beat0 at 0x100: mask 4'b0001, bus 0xAA00_0000; beat1 at 0x104: mask 4'b1110, bus 0x00DD_CCBB. Memory becomes 0xAA33_2211 / 0x88DD_CCBB.
5. SPLIT_MISALIGNED=0, lw 0x101 -> no enable pulse; resp_valid with resp_error = 1 one cycle after accept. funct3 = 011 -> same error response.
6. Assert reset during BEAT0 of a split store -> next cycle enable 0, bus Z, no resp_valid, no BEAT1, Memory unchanged. Back-to-back aligned lw requests held valid -> accepted every 2 cycles, each response matches.

Source files
------------

// File: rtl/data_memory_initiator_if.sv
// Request/response handshake between the execute/memory stage and the data memory initiator.
// The requester uses the master modport; the initiator serves requests through the slave modport.
interface data_memory_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_funct3, req_address, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_address, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_initiator.sv
// Load/store initiator for the phoeniX data memory bus: byte-lane alignment, load extension,
// and splitting of misaligned accesses into two word beats. One response per request.
module data_memory_initiator #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  data_memory_initiator_if.slave  req_if,
  output logic                    data_memory_interface_enable,
  output logic                    data_memory_interface_state,
  output logic [31:0]             data_memory_interface_address,
  output logic [3:0]              data_memory_interface_frame_mask,
  inout  wire  [31:0]             data_memory_interface_data
);

  localparam logic BUS_READ  = 1'b0;
  localparam logic BUS_WRITE = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

  state_t      r_state;
  logic        r_ready;
  logic        r_enable;
  logic        r_dir;
  logic [31:0] r_address;
  logic [3:0]  r_mask;
  logic        r_drive;
  logic [31:0] r_bus_wdata;
  logic        r_resp_valid;
  logic [31:0] r_resp_rdata;
  logic        r_resp_error;

  logic        r_write;
  logic [2:0]  r_funct3;
  logic [1:0]  r_offset;
  logic [3:0]  r_hi_lanes;
  logic        r_misaligned;
  logic [31:0] r_wdata;
  logic [31:0] r_lo;

  // Byte lanes touched across two consecutive words: bits [3:0] beat 0, bits [7:4] beat 1.
  function automatic logic [7:0] lane_span(input logic [2:0] f3, input logic [1:0] off);
    logic [7:0] base;
    case (f3[1:0])
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  function automatic logic [3:0] lanes_to_mask(input logic [3:0] lanes);
    return {lanes[0], lanes[1], lanes[2], lanes[3]};
  endfunction

  function automatic logic funct3_illegal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b0;
      default:                                return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] v, input logic [2:0] f3);
    logic signed [7:0]  sb;
    logic signed [15:0] sh;
    sb = v[7:0];
    sh = v[15:0];
    case (f3)
      3'b000:  return 32'(sb);
      3'b001:  return 32'(sh);
      3'b100:  return {24'h0, v[7:0]};
      3'b101:  return {16'h0, v[15:0]};
      default: return v;
    endcase
  endfunction

  logic [1:0]  w_in_offset;
  logic [7:0]  w_in_span;
  logic        w_in_misaligned;
  logic        w_in_reject;
  logic        w_accept;
  logic [31:0] w_bus_in;
  logic [31:0] w_lo_word;
  logic [31:0] w_hi_word;
  logic [31:0] w_merged;
  logic [31:0] w_load_result;

  assign w_in_offset     = req_if.req_address[1:0];
  assign w_in_span       = lane_span(req_if.req_funct3, w_in_offset);
  assign w_in_misaligned = |w_in_span[7:4];
  assign w_in_reject     = funct3_illegal(req_if.req_funct3) ||
                           (w_in_misaligned && !SPLIT_MISALIGNED);
  assign w_accept        = req_if.req_valid && r_ready;

  // Read data is taken straight off the bus on the posedge that closes the final beat.
  assign w_bus_in      = data_memory_interface_data;
  assign w_lo_word     = (r_state == S_BEAT0) ? w_bus_in : r_lo;
  assign w_hi_word     = (r_state == S_BEAT1) ? w_bus_in : 32'h0;
  assign w_merged      = 32'({w_hi_word, w_lo_word} >> {r_offset, 3'b000});
  assign w_load_result = extend_load(w_merged, r_funct3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_ready      <= 1'b0;
      r_enable     <= 1'b0;
      r_dir        <= BUS_READ;
      r_address    <= 32'h0;
      r_mask       <= 4'h0;
      r_drive      <= 1'b0;
      r_bus_wdata  <= 32'h0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
    end else begin
      r_ready      <= 1'b0;
      r_enable     <= 1'b0;
      r_dir        <= BUS_READ;
      r_address    <= 32'h0;
      r_mask       <= 4'h0;
      r_drive      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'h0;
      r_resp_error <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (w_accept) begin
            r_write      <= req_if.req_write;
            r_funct3     <= req_if.req_funct3;
            r_offset     <= w_in_offset;
            r_hi_lanes   <= w_in_span[7:4];
            r_misaligned <= w_in_misaligned;
            r_wdata      <= req_if.req_wdata;
            if (w_in_reject) begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_error <= 1'b1;
              r_ready      <= 1'b1;
            end else begin
              r_state     <= S_BEAT0;
              r_enable    <= 1'b1;
              r_dir       <= req_if.req_write ? BUS_WRITE : BUS_READ;
              r_address   <= {req_if.req_address[31:2], 2'b00};
              r_mask      <= lanes_to_mask(w_in_span[3:0]);
              r_drive     <= req_if.req_write;
              r_bus_wdata <= req_if.req_wdata << {w_in_offset, 3'b000};
            end
          end else begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
          end
        end
        S_BEAT0: begin
          r_lo <= w_bus_in;
          if (r_misaligned) begin
            r_state     <= S_BEAT1;
            r_enable    <= 1'b1;
            r_dir       <= r_write ? BUS_WRITE : BUS_READ;
            r_address   <= r_address + 32'd4;
            r_mask      <= lanes_to_mask(r_hi_lanes);
            r_drive     <= r_write;
            r_bus_wdata <= r_wdata >> (6'd32 - {1'b0, r_offset, 3'b000});
          end else begin
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_write ? 32'h0 : w_load_result;
            r_ready      <= 1'b1;
          end
        end
        S_BEAT1: begin
          r_state      <= S_RESP;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= r_write ? 32'h0 : w_load_result;
          r_ready      <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign req_if.req_ready                 = r_ready;
  assign req_if.resp_valid                = r_resp_valid;
  assign req_if.resp_rdata                = r_resp_rdata;
  assign req_if.resp_error                = r_resp_error;
  assign data_memory_interface_enable     = r_enable;
  assign data_memory_interface_state      = r_dir;
  assign data_memory_interface_address    = r_address;
  assign data_memory_interface_frame_mask = r_mask;
  assign data_memory_interface_data       = r_drive ? r_bus_wdata : 32'bz;

endmodule

// File: tb/tb_data_memory_initiator.sv
// Directed bench for data_memory_initiator with a negedge-responding word memory model.
module tb_data_memory_initiator;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_memory_initiator_if ifa ();
  data_memory_initiator_if ifb ();

  wire        en_a, st_a, en_b, st_b;
  wire [31:0] addr_a, addr_b, dbus_a, dbus_b;
  wire [3:0]  mask_a, mask_b;

  logic        rsp_drv = 1'b0;
  logic [31:0] rsp_dq = 32'h0;
  assign dbus_a = rsp_drv ? rsp_dq : 32'bz;

  data_memory_initiator #(.SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .reset(reset), .req_if(ifa),
    .data_memory_interface_enable(en_a), .data_memory_interface_state(st_a),
    .data_memory_interface_address(addr_a), .data_memory_interface_frame_mask(mask_a),
    .data_memory_interface_data(dbus_a)
  );

  data_memory_initiator #(.SPLIT_MISALIGNED(1'b0)) u_dut_ns (
    .clk(clk), .reset(reset), .req_if(ifb),
    .data_memory_interface_enable(en_b), .data_memory_interface_state(st_b),
    .data_memory_interface_address(addr_b), .data_memory_interface_frame_mask(mask_b),
    .data_memory_interface_data(dbus_b)
  );

  // Word memory indexed by address[9:2]; responds on the negedge inside each beat.
  logic [31:0] mem [0:255];
  logic [7:0]  idx;
  logic        pk_go = 1'b0;
  logic [7:0]  pk_idx = 8'h0;
  logic [31:0] pk_val = 32'h0;
  int          beat_cnt = 0;
  logic [31:0] b_addr [0:63];
  logic [3:0]  b_mask [0:63];
  logic        b_dir  [0:63];
  logic [31:0] b_data [0:63];
  int          en_b_cnt = 0;

  always @(negedge clk) begin
    rsp_drv = 1'b0;
    if (pk_go) mem[pk_idx] = pk_val;
    if (!reset && en_a) begin
      idx = addr_a[9:2];
      b_addr[beat_cnt % 64] = addr_a;
      b_mask[beat_cnt % 64] = mask_a;
      b_dir[beat_cnt % 64]  = st_a;
      b_data[beat_cnt % 64] = dbus_a;
      if (st_a) begin
        for (int k = 0; k < 4; k++)
          if (mask_a[3-k]) mem[idx][8*k +: 8] = dbus_a[8*k +: 8];
      end else begin
        rsp_dq  = mem[idx];
        rsp_drv = 1'b1;
      end
      beat_cnt++;
    end
    if (en_b || st_b || (mask_b != 4'h0) || (addr_b != 32'h0) || (dbus_b == 32'hDEAD_BEEF && en_b))
      en_b_cnt++;
  end

  int vectors = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic poke(input int i, input logic [31:0] v);
    pk_idx = i[7:0];
    pk_val = v;
    pk_go  = 1'b1;
    @(negedge clk);
    #1 pk_go = 1'b0;
  endtask

  task automatic send(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    ifa.req_write   = wr;
    ifa.req_funct3  = f3;
    ifa.req_address = a;
    ifa.req_wdata   = wd;
    ifa.req_valid   = 1'b1;
    while (!ifa.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready", ifa.req_ready, 1'b1);
    @(posedge clk);
    #1 ifa.req_valid = 1'b0;
  endtask

  task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output logic [31:0] rd, output logic er, output int nb, output int s);
    s = beat_cnt;
    send(wr, f3, a, wd);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ifa.resp_valid && lat < 8);
    rd = ifa.resp_rdata;
    er = ifa.resp_error;
    nb = beat_cnt - s;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, nb, s, rv;
    logic [31:0] rd;
    logic er;

    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_funct3 = 3'b000;
    ifa.req_address = 32'h0; ifa.req_wdata = 32'h0;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_funct3 = 3'b000;
    ifb.req_address = 32'h0; ifb.req_wdata = 32'h0;

    // Reset held, with a request presented that must be ignored
    repeat (2) @(negedge clk);
    ifa.req_funct3 = 3'b010; ifa.req_address = 32'h100; ifa.req_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", ifa.req_ready, 1'b0);
    check("rst_enable", en_a, 1'b0);
    check("rst_state", st_a, 1'b0);
    check("rst_address", addr_a, 32'h0);
    check("rst_mask", mask_a, 4'h0);
    check("rst_resp_valid", ifa.resp_valid, 1'b0);
    check("rst_resp_rdata", ifa.resp_rdata, 32'h0);
    check("rst_resp_error", ifa.resp_error, 1'b0);
    ifa.req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", ifa.req_ready, 1'b1);
    check("idle_enable", en_a, 1'b0);

    // Byte loads
    poke(64, 32'h8877_6655);
    txn(1'b0, 3'b000, 32'h101, 32'h0, lat, rd, er, nb, s);
    check("lb101_beats", nb, 1);
    check("lb101_addr", b_addr[s % 64], 32'h100);
    check("lb101_mask", b_mask[s % 64], 4'b0100);
    check("lb101_dir", b_dir[s % 64], 1'b0);
    check("lb101_latency", lat, 2);
    check("lb101_rdata", rd, 32'h0000_0066);
    check("lb101_error", er, 1'b0);
    txn(1'b0, 3'b000, 32'h103, 32'h0, lat, rd, er, nb, s);
    check("lb103_rdata", rd, 32'hFFFF_FF88);
    txn(1'b0, 3'b100, 32'h103, 32'h0, lat, rd, er, nb, s);
    check("lbu103_rdata", rd, 32'h0000_0088);

    // Aligned halfword store
    txn(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, lat, rd, er, nb, s);
    check("sh102_beats", nb, 1);
    check("sh102_addr", b_addr[s % 64], 32'h100);
    check("sh102_mask", b_mask[s % 64], 4'b0011);
    check("sh102_dir", b_dir[s % 64], 1'b1);
    check("sh102_bus", b_data[s % 64], 32'hABCD_0000);
    check("sh102_mem", mem[64], 32'hABCD_6655);
    check("sh102_rdata", rd, 32'h0);
    check("sh102_error", er, 1'b0);
    check("sh102_latency", lat, 2);

    // Split word load
    poke(64, 32'h4433_2211);
    poke(65, 32'h8877_6655);
    txn(1'b0, 3'b010, 32'h102, 32'h0, lat, rd, er, nb, s);
    check("lw102_beats", nb, 2);
    check("lw102_b0_addr", b_addr[s % 64], 32'h100);
    check("lw102_b0_mask", b_mask[s % 64], 4'b0011);
    check("lw102_b1_addr", b_addr[(s + 1) % 64], 32'h104);
    check("lw102_b1_mask", b_mask[(s + 1) % 64], 4'b1100);
    check("lw102_rdata", rd, 32'h6655_4433);
    check("lw102_latency", lat, 3);

    // Split word store
    txn(1'b1, 3'b010, 32'h103, 32'hDDCC_BBAA, lat, rd, er, nb, s);
    check("sw103_beats", nb, 2);
    check("sw103_b0_mask", b_mask[s % 64], 4'b0001);
    check("sw103_b0_bus", b_data[s % 64], 32'hAA00_0000);
    check("sw103_b1_addr", b_addr[(s + 1) % 64], 32'h104);
    check("sw103_b1_mask", b_mask[(s + 1) % 64], 4'b1110);
    check("sw103_b1_bus", b_data[(s + 1) % 64], 32'h00DD_CCBB);
    check("sw103_mem0", mem[64], 32'hAA33_2211);
    check("sw103_mem1", mem[65], 32'h88DD_CCBB);
    check("sw103_rdata", rd, 32'h0);
    check("sw103_latency", lat, 3);

    // Halfword straddling the top of the address space
    poke(255, 32'hAB99_8877);
    poke(0, 32'h1234_56CD);
    txn(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, lat, rd, er, nb, s);
    check("lhwrap_beats", nb, 2);
    check("lhwrap_b0_addr", b_addr[s % 64], 32'hFFFF_FFFC);
    check("lhwrap_b0_mask", b_mask[s % 64], 4'b0001);
    check("lhwrap_b1_addr", b_addr[(s + 1) % 64], 32'h0000_0000);
    check("lhwrap_b1_mask", b_mask[(s + 1) % 64], 4'b1000);
    check("lhwrap_rdata", rd, 32'hFFFF_CDAB);

    // Illegal funct3
    txn(1'b0, 3'b011, 32'h100, 32'h0, lat, rd, er, nb, s);
    check("ill_beats", nb, 0);
    check("ill_latency", lat, 1);
    check("ill_error", er, 1'b1);
    check("ill_rdata", rd, 32'h0);

    // Instance without splitting: misaligned and illegal requests rejected
    @(negedge clk);
    ifb.req_write = 1'b0; ifb.req_funct3 = 3'b010; ifb.req_address = 32'h101; ifb.req_valid = 1'b1;
    check("ns_ready", ifb.req_ready, 1'b1);
    @(posedge clk);
    #1 ifb.req_valid = 1'b0;
    @(negedge clk);
    check("ns_mis_resp_valid", ifb.resp_valid, 1'b1);
    check("ns_mis_error", ifb.resp_error, 1'b1);
    check("ns_mis_rdata", ifb.resp_rdata, 32'h0);
    @(negedge clk);
    check("ns_resp_one_cycle", ifb.resp_valid, 1'b0);
    ifb.req_funct3 = 3'b011; ifb.req_address = 32'h100; ifb.req_valid = 1'b1;
    @(posedge clk);
    #1 ifb.req_valid = 1'b0;
    @(negedge clk);
    check("ns_ill_resp_valid", ifb.resp_valid, 1'b1);
    check("ns_ill_error", ifb.resp_error, 1'b1);
    check("ns_no_bus_activity", en_b_cnt, 0);

    // Reset during the first beat of a split store
    s = beat_cnt;
    send(1'b1, 3'b010, 32'h101, 32'h1122_3344);
    reset = 1'b1;
    @(negedge clk);
    check("abort_in_beat0", en_a, 1'b1);
    @(negedge clk);
    check("abort_enable", en_a, 1'b0);
    check("abort_resp_valid", ifa.resp_valid, 1'b0);
    check("abort_ready", ifa.req_ready, 1'b0);
    rv = 0;
    repeat (4) begin
      @(negedge clk);
      if (ifa.resp_valid || en_a) rv++;
    end
    check("abort_quiet", rv, 0);
    check("abort_beats", beat_cnt - s, 0);
    check("abort_mem0", mem[64], 32'hAA33_2211);
    check("abort_mem1", mem[65], 32'h88DD_CCBB);
    reset = 1'b0;
    @(negedge clk);
    check("abort_ready_again", ifa.req_ready, 1'b1);

    // Back-to-back aligned loads with valid held
    ifa.req_write = 1'b0; ifa.req_funct3 = 3'b010; ifa.req_address = 32'h100; ifa.req_valid = 1'b1;
    @(negedge clk);
    check("b2b_busy", ifa.req_ready, 1'b0);
    check("b2b_b0_addr", addr_a, 32'h100);
    ifa.req_address = 32'h104;
    @(negedge clk);
    check("b2b_r0_valid", ifa.resp_valid, 1'b1);
    check("b2b_r0_rdata", ifa.resp_rdata, 32'hAA33_2211);
    check("b2b_r0_ready", ifa.req_ready, 1'b1);
    @(negedge clk);
    check("b2b_second_beat", en_a, 1'b1);
    check("b2b_b1_addr", addr_a, 32'h104);
    ifa.req_valid = 1'b0;
    @(negedge clk);
    check("b2b_r1_valid", ifa.resp_valid, 1'b1);
    check("b2b_r1_rdata", ifa.resp_rdata, 32'h88DD_CCBB);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
